// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared types for the load/store unit (state, access width)
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef logic [1:0] data_width_t;

    localparam data_width_t DW_BYTE = 2'b00;
    localparam data_width_t DW_HALF = 2'b01;
    localparam data_width_t DW_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RETIRE = 2'd2
    } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : alignment check, byte-enable/store steering, load extension
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  data_width_t req_dw,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic        req_ok,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata_steer,
    input  data_width_t rd_dw,
    input  logic        rd_uns,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        req_ok          = 1'b0;
        req_be          = 4'b0000;
        req_wdata_steer = req_wdata;
        case (req_dw)
            DW_BYTE: begin
                req_ok          = 1'b1;
                req_be          = 4'b0001 << req_off;
                req_wdata_steer = {4{req_wdata[7:0]}};
            end
            DW_HALF: begin
                req_ok          = ~req_off[0];
                req_be          = 4'b0011 << req_off;
                req_wdata_steer = {2{req_wdata[15:0]}};
            end
            DW_WORD: begin
                req_ok          = (req_off == 2'b00);
                req_be          = 4'b1111;
            end
            default: begin
                req_ok          = 1'b0;
                req_be          = 4'b0000;
            end
        endcase
    end

    always_comb begin
        case (rd_off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = rd_off[1] ? rd_word[31:16] : rd_word[15:0];

        case (rd_dw)
            DW_BYTE: rd_ext = {{24{rd_byte[7] & ~rd_uns}}, rd_byte};
            DW_HALF: rd_ext = {{16{rd_half[15] & ~rd_uns}}, rd_half};
            default: rd_ext = rd_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// lsu : single-outstanding load/store unit with timeout and fault reporting
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        l,
    input  logic        s,
    input  data_width_t dw,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_t        state_q, state_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    data_width_t       dw_q, dw_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              req_ok;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_steer;
    logic [31:0]       rd_ext;
    logic              go;
    logic              fault;
    logic [CNT_W-1:0]  cnt_inc;

    lsu_align u_align (
        .req_dw          (dw),
        .req_off         (addr[1:0]),
        .req_wdata       (wdata),
        .req_ok          (req_ok),
        .req_be          (req_be),
        .req_wdata_steer (req_wdata_steer),
        .rd_dw           (dw_q),
        .rd_uns          (uns_q),
        .rd_off          (off_q),
        .rd_word         (mem_rdata),
        .rd_ext          (rd_ext)
    );

    // Simultaneous load+store, an illegal width and misalignment all fault alike.
    assign go      = (l ^ s) & req_ok;
    assign fault   = (l | s) & ~go;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        dw_d        = dw_q;
        uns_d       = uns_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d     = ST_ACCESS;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = req_be;
                    mem_wdata_d = req_wdata_steer;
                    mem_we_d    = s;
                    dw_d        = dw;
                    uns_d       = uns;
                    off_d       = addr[1:0];
                    cnt_d       = '0;
                end else if (fault) begin
                    err_d       = 1'b1;
                end
            end
            ST_ACCESS: begin
                // A ready on the timeout edge still completes the access.
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        load_data_d = rd_ext;
                    end
                    state_d = ST_RETIRE;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            dw_q        <= DW_BYTE;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            load_data_q <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            dw_q        <= dw_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = (state_q == ST_ACCESS);
    assign done      = (state_q == ST_RETIRE);
    assign err       = err_q;
    assign stall     = (state_q == ST_ACCESS) | ((state_q == ST_IDLE) & go);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign load_data = load_data_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// tb_lsu : directed scoreboard bench for the load/store unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l = 1'b0;
    logic        s = 1'b0;
    data_width_t dw = DW_BYTE;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        stall, done, err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    typedef struct packed {
        logic        is_err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_ld = '0;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .l         (l),
        .s         (s),
        .dw        (dw),
        .uns       (uns),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: retire/fault pulses pop the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            check("done_err_exclusive", {31'd0, done & err}, 32'd0);
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_response: got done=%b err=%b expected none", done, err);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_is_err", {31'd0, err}, {31'd0, e.is_err});
                if (e.chk) check("load_data", load_data, e.data);
            end
        end
    end

    task automatic do_access(input logic il, input logic is_, input data_width_t idw,
                             input logic iuns, input logic [31:0] iaddr,
                             input logic [31:0] iwdata, input logic [31:0] irdata,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic [31:0] ed, input int waits, input logic etimeout);
        l = il; s = is_; dw = idw; uns = iuns; addr = iaddr; wdata = iwdata;
        #1 check("stall_req", {31'd0, stall}, 32'd1);
        if (etimeout) begin
            sbq.push_back('{1'b1, 1'b0, 32'h0});
        end else begin
            if (il) last_ld = ed;
            sbq.push_back('{1'b0, 1'b1, last_ld});
        end
        tick;
        l = 1'b0; s = 1'b0;
        check("mem_req", {31'd0, mem_req}, 32'd1);
        check("mem_addr", mem_addr, {iaddr[31:2], 2'b00});
        check("mem_be", {28'd0, mem_be}, {28'd0, ebe});
        check("mem_we", {31'd0, mem_we}, {31'd0, is_});
        if (is_) check("mem_wdata", mem_wdata, ewd);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            tick;
        end
        if (etimeout) begin
            check("timeout_mem_req", {31'd0, mem_req}, 32'd0);
            check("timeout_err", {31'd0, err}, 32'd1);
            check("timeout_stall", {31'd0, stall}, 32'd0);
        end else begin
            check("wait_mem_req", {31'd0, mem_req}, 32'd1);
            mem_ready = 1'b1;
            mem_rdata = irdata;
            tick;
            mem_ready = 1'b0;
            check("retire_done", {31'd0, done}, 32'd1);
            check("retire_stall", {31'd0, stall}, 32'd0);
        end
        tick;
    endtask

    task automatic do_fault(input logic il, input logic is_, input data_width_t idw,
                            input logic [31:0] iaddr);
        l = il; s = is_; dw = idw; addr = iaddr;
        #1 check("fault_stall", {31'd0, stall}, 32'd0);
        sbq.push_back('{1'b1, 1'b0, 32'h0});
        tick;
        l = 1'b0; s = 1'b0;
        check("fault_no_req", {31'd0, mem_req}, 32'd0);
        check("fault_err", {31'd0, err}, 32'd1);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_flags", {29'd0, done, err, mem_req}, 32'd0);
        check("rst_we_be", {27'd0, mem_we, mem_be}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        rst_n = 1'b1;
        tick;

        // il is_ dw uns addr wdata rdata be wdata_exp data_exp waits timeout
        do_access(1'b0, 1'b1, DW_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,
                  4'b1111, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        do_access(1'b1, 1'b0, DW_BYTE, 1'b0, 32'h203, 32'h0, 32'h80FF1234,
                  4'b1000, 32'h0, 32'hFFFFFF80, 0, 1'b0);
        do_access(1'b1, 1'b0, DW_BYTE, 1'b1, 32'h203, 32'h0, 32'h80FF1234,
                  4'b1000, 32'h0, 32'h00000080, 1, 1'b0);
        do_access(1'b0, 1'b1, DW_HALF, 1'b0, 32'h302, 32'h0000A5A5, 32'h0,
                  4'b1100, 32'hA5A5A5A5, 32'h0, 0, 1'b0);
        do_fault(1'b1, 1'b0, DW_HALF, 32'h301);
        do_access(1'b1, 1'b0, DW_HALF, 1'b0, 32'h402, 32'h0, 32'h80017FFF,
                  4'b1100, 32'h0, 32'hFFFF8001, 3, 1'b0);
        do_access(1'b1, 1'b0, DW_HALF, 1'b1, 32'h400, 32'h0, 32'h80019234,
                  4'b0011, 32'h0, 32'h00009234, 0, 1'b0);
        do_access(1'b1, 1'b0, DW_WORD, 1'b0, 32'h500, 32'h0, 32'h0,
                  4'b1111, 32'h0, 32'h0, 4, 1'b1);
        do_fault(1'b1, 1'b1, DW_WORD, 32'h600);
        do_fault(1'b1, 1'b0, 2'b11, 32'h600);
        do_fault(1'b0, 1'b1, DW_WORD, 32'h102);
        do_access(1'b0, 1'b1, DW_BYTE, 1'b0, 32'h601, 32'h12345678, 32'h0,
                  4'b0010, 32'h78787878, 32'h0, 2, 1'b0);
        do_access(1'b1, 1'b0, DW_BYTE, 1'b0, 32'h601, 32'h0, 32'h0000F200,
                  4'b0010, 32'h0, 32'hFFFFFFF2, 0, 1'b0);

        // Abandon an access with reset, then confirm a clean follow-up load.
        l = 1'b1; dw = DW_WORD; addr = 32'h800;
        tick;
        l = 1'b0;
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        last_ld = 32'h0;
        tick;
        rst_n = 1'b1;
        tick;
        do_access(1'b1, 1'b0, DW_WORD, 1'b0, 32'h700, 32'h0, 32'hCAFEF00D,
                  4'b1111, 32'h0, 32'hCAFEF00D, 1, 1'b0);

        repeat (3) tick;
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute datapath. It takes the effective address, store data and memory control bits (load, store, width, unsigned) and runs a single outstanding access to data memory over a ready-handshake bus. It performs byte-lane steering on stores, extraction and sign/zero extension on loads, and misalignment and timeout detection. It holds the pipeline stall high until the access retires.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `mem_req` may wait for `mem_ready` before the access aborts. Range 1..65535.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `l` input 1: load request, sampled in IDLE.
- `s` input 1: store request, sampled in IDLE.
- `dw` input `data_width`: access width (BYTE, HALF, WORD).
- `uns` input 1: zero-extend the load (func3[2]); ignored for stores.
- `addr` input 32: byte effective address.
- `wdata` input 32: store data, right-aligned.
- `stall` output 1: pipeline hold.
- `done` output 1: one-cycle retire pulse.
- `err` output 1: one-cycle fault pulse (misaligned, illegal, or timeout).
- `load_data` output 32: extended load result, valid while `done`=1.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write.
- `mem_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-steered store data.
- `mem_ready` input 1: bus completion.
- `mem_rdata` input 32: read word, valid when `mem_ready`=1.

## Operation
- States: IDLE, ACCESS, RETIRE.
- **IDLE, `l` XOR `s` = 1:**
  - If aligned: register `mem_addr`/`mem_be`/`mem_wdata`/`mem_we`/width/`uns`/`addr[1:0]`, clear the timeout counter, go to ACCESS.
- **Alignment rule:**
  - HALF requires `addr[0]`=0.
  - WORD requires `addr[1:0]`=0.
  - BYTE is always aligned.
- **IDLE, fault:** misaligned, `l`&`s`=1, or `dw`=2'b11 → `err` pulses next cycle, no bus activity, stay in IDLE.
- **ACCESS:**
  - `mem_req`=1 with all bus outputs held stable.
  - If `mem_ready`=1 at the edge: capture the extended read data into `load_data` (loads only) and go to RETIRE.
  - Else increment the counter. When the counter reaches `TIMEOUT_CYCLES`, drop `mem_req`, pulse `err`, return to IDLE.
- **RETIRE:** `done`=1 for exactly one cycle, then IDLE.
- **Byte enables:** BYTE = `4'b0001<<addr[1:0]`; HALF = `4'b0011<<addr[1:0]`; WORD = `4'b1111`.
- **Store steering:**
  - BYTE: `wdata[7:0]` replicated to all lanes.
  - HALF: `wdata[15:0]` replicated to both halves.
  - WORD: as-is.
- **Load extraction:** select the lane by `addr[1:0]`. Sign-extend from bit 7 or 15 unless `uns`=1. WORD is passed through.
- **Store result:** `load_data` is unchanged by stores.
- `l`/`s` asserted outside IDLE are ignored; upstream holds them under `stall`.

## Timing
- **Reset values:** IDLE; `stall`, `done`, `err`, `mem_req`, `mem_we` = 0; `mem_be`=0; `mem_addr`, `mem_wdata`, `load_data` = 0; counter = 0.
- **Reset mid-access:** `mem_req` drops asynchronously; the access is abandoned with no `done` or `err`.
- **`stall`:** combinational, = (state≠IDLE) | (IDLE & (`l`|`s`) & no fault).
  - Going high in the request cycle freezes upstream immediately.
  - Drops in the RETIRE cycle.
- **Minimum latency:** request at cycle 0; `mem_req` in cycle 1; `mem_ready` in cycle 1 gives `done` in cycle 2.
- **Wait states:** each cycle of `mem_ready`=0 adds one cycle.
- **Timeout:** `err` is asserted in the cycle after the `TIMEOUT_CYCLES`-th wait cycle; `mem_req` is low in that same cycle.
- **Ready vs. timeout:** a `mem_ready` that coincides with the timeout edge wins (completes normally).
- `mem_ready` is ignored outside ACCESS.
- `done` and `err` are never high together.
- **Counter:** width `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.

## Structure
- `defs.svh` gains `lsu_state_t` (IDLE/ACCESS/RETIRE, 2-bit enum).
- `data_width` encoding, also in `defs.svh`: BYTE=2'b00, HALF=2'b01, WORD=2'b10; 2'b11 is illegal.
- Sub-module `lsu_align` (combinational) holds the alignment check, `mem_be`/`mem_wdata` generation and load extraction/extension.
- The `lsu` top holds the FSM, registers and timeout counter.

## Test plan
- **Word store:** `s`=1, WORD, `addr`=0x100, `wdata`=0xDEADBEEF, `mem_ready` immediate → `mem_addr`=0x100, `mem_be`=1111, `mem_we`=1 in cycle 1, `done` in cycle 2, `stall` high in cycles 0–1.
- **Byte load, sign-extend:** `l`=1, BYTE, `uns`=0, `addr`=0x203, `mem_rdata`=0x80FF1234 → `mem_be`=1000, `load_data`=0xFFFFFF80. Same with `uns`=1 → 0x00000080.
- **Half store, upper half:** HALF, `addr`=0x302, `wdata`=0x0000A5A5 → `mem_be`=1100, `mem_wdata`=0xA5A5A5A5. Half load with `addr`=0x301 → `err` next cycle, `mem_req` never rises.
- **Wait states and timeout:** `TIMEOUT_CYCLES`=4.
  - `mem_ready` after 3 waits → `done`, no `err`.
  - `mem_ready` never → `err` one cycle after 4 waits, `mem_req`=0, back to IDLE.
- **Reset and illegal requests:**
  - `rst_n` low during ACCESS → `mem_req` and `stall` = 0 immediately; after release, a new load completes normally.
  - `l`=`s`=1 → `err`, no bus request.
